// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sharing one APB master port among NUM_REQ requesters
module apb_req_arbiter #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*addrWidth-1:0]   req_addr,
  input  logic [NUM_REQ*dataWidth-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err,
  output logic [dataWidth-1:0]           rdata,
  output logic                           busy,
  output logic [addrWidth-1:0]           paddr,
  output logic                           pwrite,
  output logic                           psel,
  output logic                           penable,
  output logic [dataWidth-1:0]           pwdata,
  input  logic                           pready,
  input  logic [dataWidth-1:0]           prdata
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [PW-1:0] ptr, own, win;
  logic [CW-1:0] cnt;
  logic timed_out;
  function automatic logic [PW-1:0] wrap(input int v);
    return (v >= NUM_REQ) ? PW'(v - NUM_REQ) : PW'(v);
  endfunction
  // Scan downward so the requester closest to ptr is written last and wins.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[wrap(int'(ptr) + i)]) win = wrap(int'(ptr) + i);
  end
  assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign busy = (state != IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      own     <= '0;
      cnt     <= '0;
      grant   <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwdata  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          paddr   <= req_addr[int'(win)*addrWidth +: addrWidth];
          pwdata  <= req_wdata[int'(win)*dataWidth +: dataWidth];
          pwrite  <= req_write[win];
          psel    <= 1'b1;
          penable <= 1'b0;
          grant   <= NUM_REQ'(1) << win;
          own     <= win;
          ptr     <= wrap(int'(win) + 1);
          state   <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (!pready) cnt <= cnt + 1'b1;
          if (pready || timed_out) begin
            if (pready && !pwrite) rdata <= prdata;
            done    <= NUM_REQ'(1) << own;
            err     <= !pready;
            psel    <= 1'b0;
            penable <= 1'b0;
            grant   <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
